// File: rtl/down_count_pkg.sv
// Shared definitions for the down-count controller: FSM state encoding,
// default datapath width and a state-decode helper.
package down_count_pkg;

    localparam int COUNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == RUN) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/down_counter_core.sv
// Saturating down-counter datapath: clear beats load, load beats decrement,
// and a decrement at zero is ignored.
module down_counter_core
    import down_count_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [COUNT_W-1:0] load_value_i,
    input  logic               dec_i,
    input  logic               clr_i,
    output logic [COUNT_W-1:0] count_o
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        // NOTE: the default assignment first means no path leaves count_d unassigned, so no latch.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/down_count_ctrl.sv
// Load/run/pause/abort countdown FSM driving down_counter_core.
// Define DOWN_COUNT_CTRL_AUTO_RELOAD_EN to restart from the last loaded value after each completion.
module down_count_ctrl
    import down_count_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [COUNT_W-1:0] load_value,
    output logic               load_ready,
    input  logic               tick,
    input  logic               pause,
    input  logic               abort,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done
);

    state_e             state_q;
    state_e             state_d;
    logic               done_q;
    logic               core_load;
    logic               core_dec;
    logic               core_clr;
    logic [COUNT_W-1:0] core_load_value;
    logic [COUNT_W-1:0] count_w;

`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
    logic [COUNT_W-1:0] reload_q;

    // NOTE: reload_q is reset, otherwise a stale value could restart a countdown after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
        end else if ((state_q == IDLE) && load_valid) begin
            reload_q <= load_value;
        end
    end
`endif

    always_comb begin
        state_d         = state_q;
        core_load       = 1'b0;
        core_load_value = load_value;
        core_dec        = 1'b0;
        core_clr        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    core_load = 1'b1;
                    state_d   = (load_value != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = IDLE;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    core_dec = 1'b1;
                    if (count_w == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSED: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = IDLE;
                end else begin
`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
                    if (reload_q != '0) begin
                        core_load       = 1'b1;
                        core_load_value = reload_q;
                        state_d         = RUN;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
        end
    end

    down_counter_core #(
        .COUNT_W (COUNT_W)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .load_i       (core_load),
        .load_value_i (core_load_value),
        .dec_i        (core_dec),
        .clr_i        (core_clr),
        .count_o      (count_w)
    );

    assign count      = count_w;
    assign done       = done_q;
    assign busy       = is_busy(state_q);
    assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_down_count_ctrl.sv
// Self-checking bench for down_count_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a behavioural model.
module tb_down_count_ctrl;

    localparam int COUNT_W = 4;
`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int PH_IDLE   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_PAUSED = 2;
    localparam int PH_DONE   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_valid;
    logic [COUNT_W-1:0] load_value;
    logic               load_ready;
    logic               tick;
    logic               pause;
    logic               abort;
    logic [COUNT_W-1:0] count;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    int m_phase  = PH_IDLE;
    int m_count  = 0;
    int m_reload = 0;

    always #5 clk = ~clk;

    down_count_ctrl #(
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .tick       (tick),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: the countdown described as phases and integer arithmetic.
    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= PH_IDLE;
            m_count  <= 0;
            m_reload <= 0;
        end else if (abort && (m_phase != PH_IDLE)) begin
            m_phase <= PH_IDLE;
            m_count <= 0;
        end else if (m_phase == PH_IDLE) begin
            if (load_valid) begin
                m_count  <= int'(load_value);
                m_reload <= int'(load_value);
                m_phase  <= (int'(load_value) != 0) ? PH_RUN : PH_DONE;
            end
        end else if (m_phase == PH_DONE) begin
            if (AUTO && (m_reload != 0)) begin
                m_count <= m_reload;
                m_phase <= PH_RUN;
            end else begin
                m_phase <= PH_IDLE;
            end
        end else if (m_phase == PH_PAUSED) begin
            if (!pause) m_phase <= PH_RUN;
        end else begin
            if (pause) begin
                m_phase <= PH_PAUSED;
            end else if (tick && (m_count > 0)) begin
                m_count <= m_count - 1;
                if (m_count == 1) m_phase <= PH_DONE;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_count", 32'(count), m_count);
            check("model_busy", 32'(busy), 32'((m_phase == PH_RUN) || (m_phase == PH_PAUSED)));
            check("model_done", 32'(done), 32'(m_phase == PH_DONE));
            check("model_load_ready", 32'(load_ready), 32'(m_phase == PH_IDLE));
        end
    end

    task automatic next();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_value = '0;
        tick       = 1'b0;
        pause      = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic load(input int v);
        load_valid = 1'b1;
        load_value = COUNT_W'(v);
        next();
        load_valid = 1'b0;
    endtask

    // From DONE: the default build drops to IDLE on its own; auto-reload needs an abort.
    task automatic leave_done();
        abort = AUTO;
        next();
        abort = 1'b0;
        check("leave_done_ready", 32'(load_ready), 1);
        check("leave_done_pulse", 32'(done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        next();
        cmp_en = 1'b1;

        // Reset held with random inputs.
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_value = COUNT_W'($urandom);
            tick       = 1'($urandom_range(0, 1));
            pause      = 1'($urandom_range(0, 1));
            abort      = 1'($urandom_range(0, 1));
            next();
        end
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(load_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        idle_inputs();
        rst = 1'b0;
        next();

        // Load 4, tick every cycle.
        tick = 1'b1;
        load(4);
        check("s4_load_count", 32'(count), 4);
        check("s4_load_busy", 32'(busy), 1);
        for (int e = 3; e >= 1; e--) begin
            next();
            check("s4_count", 32'(count), e);
            check("s4_no_done", 32'(done), 0);
        end
        next();
        check("s4_zero_count", 32'(count), 0);
        check("s4_done", 32'(done), 1);
        tick = 1'b0;
        leave_done();

        // Load 5, pause for 3 cycles at count 3 with tick held high.
        tick = 1'b1;
        load(5);
        next();
        next();
        check("s5_pre_pause", 32'(count), 3);
        pause = 1'b1;
        repeat (3) next();
        check("s5_paused_count", 32'(count), 3);
        check("s5_paused_busy", 32'(busy), 1);
        pause = 1'b0;
        next();
        check("s5_resume_count", 32'(count), 3);
        next();
        next();
        check("s5_one", 32'(count), 1);
        check("s5_one_no_done", 32'(done), 0);
        next();
        check("s5_done", 32'(done), 1);
        tick = 1'b0;
        leave_done();

        // Load 0: straight to the done pulse, never busy.
        load(0);
        check("s0_done", 32'(done), 1);
        check("s0_busy", 32'(busy), 0);
        next();
        check("s0_after_done", 32'(done), 0);
        check("s0_after_busy", 32'(busy), 0);
        check("s0_after_ready", 32'(load_ready), 1);

        // Load 9, abort at 6 together with tick, then reload 2.
        tick = 1'b1;
        load(9);
        repeat (3) next();
        check("s9_count6", 32'(count), 6);
        abort = 1'b1;
        next();
        abort = 1'b0;
        check("s9_abort_count", 32'(count), 0);
        check("s9_abort_ready", 32'(load_ready), 1);
        check("s9_abort_done", 32'(done), 0);
        load(2);
        check("s9_reload_count", 32'(count), 2);
        next();
        next();
        check("s9_reload_done", 32'(done), 1);
        tick = 1'b0;
        leave_done();

        // Abort in IDLE does not block a load; abort in PAUSED returns to IDLE.
        abort = 1'b1;
        load(3);
        abort = 1'b0;
        check("idle_abort_count", 32'(count), 3);
        check("idle_abort_busy", 32'(busy), 1);
        pause = 1'b1;
        next();
        abort = 1'b1;
        next();
        abort = 1'b0;
        pause = 1'b0;
        check("pause_abort_count", 32'(count), 0);
        check("pause_abort_ready", 32'(load_ready), 1);

`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
        // Auto-reload: load 3 with continuous ticks gives a done pulse every 4 cycles.
        tick = 1'b1;
        load(3);
        for (int i = 0; i < 12; i++) begin
            next();
            check("auto_done", 32'(done), 32'((i % 4) == 2));
        end
        abort = 1'b1;
        next();
        abort = 1'b0;
        tick  = 1'b0;
        check("auto_abort_ready", 32'(load_ready), 1);
        check("auto_abort_count", 32'(count), 0);
`endif

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            load_valid = 1'($urandom_range(0, 1));
            load_value = COUNT_W'($urandom);
            tick       = ($urandom_range(0, 99) < 70);
            pause      = ($urandom_range(0, 99) < 15);
            abort      = ($urandom_range(0, 99) < 5);
            next();
        end
        rst = 1'b0;
        idle_inputs();
        next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
